// File: rtl/eth_sched_pkg.sv
// eth_sched_pkg: frame-select and FSM state enums plus ARP opcode constants
// shared by the eth_tx scheduler and its ARP retry helper.
package eth_sched_pkg;
   typedef enum logic [1:0] {SEL_NONE, SEL_ARP_RESP, SEL_ARP_RQ, SEL_UDP} tx_sel_t;
   typedef enum logic [1:0] {IDLE, START, BUSY, IFG} state_t;
   localparam logic ARP_OPER_RQ   = 1'b0;
   localparam logic ARP_OPER_RESP = 1'b1;
endpackage

// File: rtl/eth_tx_sched_arp_retry.sv
// eth_arp_retry: ARP request pacing -- retry timer, retry counter, backoff
// after exhausted resolution, and the arp_fail pulse.
module eth_arp_retry
   import eth_sched_pkg::*;
#(
   parameter int unsigned ARP_RETRY_CYCLES = 125000000,
   parameter int unsigned ARP_MAX_RETRY    = 3
)(
   input  logic i_aclk,
   input  logic i_aresetn,
   input  logic i_rq_done,
   input  logic i_mac_valid,
   input  logic i_udp_pending,
   output logic o_rq_allow,
   output logic o_arp_fail
);
   localparam int CW = $clog2(ARP_MAX_RETRY + 1);
   logic [31:0]   r_timer;
   logic [CW-1:0] r_cnt;
   logic          r_backoff;
   logic          r_fail;
   logic          w_fail;
   assign w_fail     = i_rq_done & ~i_mac_valid & (r_cnt == CW'(ARP_MAX_RETRY - 1));
   assign o_rq_allow = (r_timer == '0) & ~r_backoff;
   assign o_arp_fail = r_fail;
   // A resolved MAC wipes all retry history so a later loss requests at once.
   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_timer   <= '0;
         r_cnt     <= '0;
         r_backoff <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_fail    <= w_fail;
         r_timer   <= i_mac_valid ? '0 : i_rq_done ? 32'(ARP_RETRY_CYCLES) :
                      (r_timer != '0) ? r_timer - 32'd1 : r_timer;
         r_cnt     <= (i_mac_valid | w_fail) ? '0 : i_rq_done ? r_cnt + CW'(1) : r_cnt;
         r_backoff <= w_fail | (r_backoff & i_udp_pending & ~i_mac_valid);
      end
   end
endmodule

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: shares eth_tx between ARP reply, ARP request and UDP frames.
// Optional TX_WATCHDOG_EN adds a per-frame watchdog that abandons a stuck frame.
module eth_tx_sched
   import eth_sched_pkg::*;
#(
   parameter int unsigned IFG_CYCLES       = 12,
   parameter int unsigned ARP_RETRY_CYCLES = 125000000,
   parameter int unsigned ARP_MAX_RETRY    = 3
`ifdef TX_WATCHDOG_EN
   , parameter int unsigned TX_WD_CYCLES   = 65536
`endif
)(
   input  logic       i_aclk,
   input  logic       i_aresetn,
   input  logic       i_arp_resp_req,
   output logic       o_arp_resp_ack,
   input  logic       i_mac_valid,
   input  logic       i_udp_pending,
   input  logic       i_tx_done,
   output logic       o_tx_start,
   output logic [1:0] o_tx_sel,
   output logic       o_arp_oper,
   output logic       o_udp_gate,
   output logic       o_arp_fail,
   output logic       o_tx_timeout
);
   localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   state_t        r_state;
   tx_sel_t       r_sel;
   tx_sel_t       w_sel;
   logic          r_tx_start, r_ack, r_oper, r_gate;
   logic [IW-1:0] r_ifg;
   logic          w_rq_allow, w_rq_done, w_wd_exp;
`ifdef TX_WATCHDOG_EN
   localparam int WW = $clog2(TX_WD_CYCLES + 1);
   logic [WW-1:0] r_wd;
   logic          r_timeout;
   assign w_wd_exp     = (r_state == BUSY) & ~i_tx_done & (r_wd == WW'(TX_WD_CYCLES - 1));
   assign o_tx_timeout = r_timeout;
   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_wd      <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_wd_exp;
         r_wd      <= (r_state != BUSY) ? '0 : (r_wd == WW'(TX_WD_CYCLES - 1)) ? r_wd : r_wd + WW'(1);
      end
   end
`else
   assign w_wd_exp     = 1'b0;
   assign o_tx_timeout = 1'b0;
`endif
   assign w_sel = i_arp_resp_req ? SEL_ARP_RESP :
                  (i_udp_pending & ~i_mac_valid & w_rq_allow) ? SEL_ARP_RQ :
                  (i_udp_pending & i_mac_valid) ? SEL_UDP : SEL_NONE;
   // An abandoned ARP request still counts toward the retry limit.
   assign w_rq_done = (r_state == BUSY) & (r_sel == SEL_ARP_RQ) & (i_tx_done | w_wd_exp);
   eth_arp_retry #(
      .ARP_RETRY_CYCLES(ARP_RETRY_CYCLES),
      .ARP_MAX_RETRY   (ARP_MAX_RETRY)
   ) u_retry (
      .i_aclk       (i_aclk),
      .i_aresetn    (i_aresetn),
      .i_rq_done    (w_rq_done),
      .i_mac_valid  (i_mac_valid),
      .i_udp_pending(i_udp_pending),
      .o_rq_allow   (w_rq_allow),
      .o_arp_fail   (o_arp_fail)
   );
   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_state    <= IDLE;
         r_sel      <= SEL_NONE;
         r_tx_start <= 1'b0;
         r_ack      <= 1'b0;
         r_oper     <= 1'b0;
         r_gate     <= 1'b0;
         r_ifg      <= '0;
      end else begin
         r_tx_start <= 1'b0;
         r_ack      <= 1'b0;
         case (r_state)
            IDLE: if (w_sel != SEL_NONE) begin
               r_state    <= START;
               r_sel      <= w_sel;
               r_tx_start <= 1'b1;
               r_ack      <= (w_sel == SEL_ARP_RESP);
               r_oper     <= (w_sel == SEL_ARP_RESP) ? ARP_OPER_RESP : ARP_OPER_RQ;
            end
            START: begin
               r_state <= BUSY;
               r_gate  <= (r_sel == SEL_UDP);
            end
            BUSY: if (i_tx_done | w_wd_exp) begin
               r_state <= IFG;
               r_gate  <= 1'b0;
               r_ifg   <= IW'(IFG_CYCLES - 1);
            end
            IFG: if (r_ifg == '0) begin
               r_state <= IDLE;
               r_sel   <= SEL_NONE;
               r_oper  <= 1'b0;
            end else begin
               r_ifg <= r_ifg - IW'(1);
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign o_tx_start     = r_tx_start;
   assign o_arp_resp_ack = r_ack;
   assign o_tx_sel       = r_sel;
   assign o_arp_oper     = r_oper;
   assign o_udp_gate     = r_gate;
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed scenarios plus a randomized run scored against a
// transaction-level timing model of the scheduler.
module tb_eth_tx_sched;
   localparam int IFG   = 12;
   localparam int RETRY = 100;
   localparam int MAXR  = 3;
   logic       clk = 1'b0;
   logic       i_aresetn = 1'b0, i_arp_resp_req = 1'b0, i_mac_valid = 1'b0;
   logic       i_udp_pending = 1'b0, i_tx_done = 1'b0;
   logic       o_arp_resp_ack, o_tx_start, o_arp_oper, o_udp_gate, o_arp_fail, o_tx_timeout;
   logic [1:0] o_tx_sel;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   eth_tx_sched #(
      .IFG_CYCLES(IFG), .ARP_RETRY_CYCLES(RETRY), .ARP_MAX_RETRY(MAXR)
`ifdef TX_WATCHDOG_EN
      , .TX_WD_CYCLES(50)
`endif
   ) dut (
      .i_aclk(clk), .i_aresetn(i_aresetn), .i_arp_resp_req(i_arp_resp_req),
      .o_arp_resp_ack(o_arp_resp_ack), .i_mac_valid(i_mac_valid),
      .i_udp_pending(i_udp_pending), .i_tx_done(i_tx_done), .o_tx_start(o_tx_start),
      .o_tx_sel(o_tx_sel), .o_arp_oper(o_arp_oper), .o_udp_gate(o_udp_gate),
      .o_arp_fail(o_arp_fail), .o_tx_timeout(o_tx_timeout)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #1000000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "bench did not finish");
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      i_aresetn = 1'b0; i_arp_resp_req = 1'b0; i_mac_valid = 1'b0;
      i_udp_pending = 1'b0; i_tx_done = 1'b0;
      tick(); tick();
      i_aresetn = 1'b1;
   endtask
   task automatic wait_start(input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (o_tx_start === 1'b1) begin t = cyc; break; end
      end
   endtask
   // Returns the cycle in which tx_done was high.
   task automatic finish_frame(input int len, output int d);
      repeat (len - 1) tick();
      d = cyc;
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
   endtask
   task automatic test_reset();
      logic [7:0] v;
      do_reset();
      v = {o_tx_start, o_arp_resp_ack, o_tx_sel, o_arp_oper, o_udp_gate, o_arp_fail, o_tx_timeout};
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL reset_outputs got=%b exp=00000000", v); end
      repeat (5) tick();
      v = {o_tx_start, o_arp_resp_ack, o_tx_sel, o_arp_oper, o_udp_gate, o_arp_fail, o_tx_timeout};
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL idle_quiet got=%b exp=00000000", v); end
   endtask
   task automatic test_arp_reply();
      int s, d, t;
      do_reset();
      i_arp_resp_req = 1'b1;
      tick();
      s = cyc;
      checks++;
      if ({o_tx_start, o_tx_sel, o_arp_oper, o_arp_resp_ack} !== 5'b1_01_1_1) begin
         errors++;
         $display("FAIL reply_start got=%b exp=10111", {o_tx_start, o_tx_sel, o_arp_oper, o_arp_resp_ack});
      end
      i_arp_resp_req = 1'b0;
      tick();
      checks++;
      if ({o_tx_start, o_arp_resp_ack, o_tx_sel} !== 4'b00_01) begin
         errors++;
         $display("FAIL reply_pulse got=%b exp=0001", {o_tx_start, o_arp_resp_ack, o_tx_sel});
      end
      i_udp_pending = 1'b1; i_mac_valid = 1'b1;
      finish_frame(59, d);
      wait_start(40, t);
      checks++;
      if (t < 0 || t - d != IFG + 2 || o_tx_sel !== 2'd3 || o_arp_resp_ack !== 1'b0) begin
         errors++;
         $display("FAIL reply_ifg_gap got gap=%0d sel=%0d exp gap=%0d sel=3 (start %0d)", t - d, o_tx_sel, IFG + 2, s);
      end
   endtask
   task automatic test_arp_retry();
      int d, t, nf, ns;
      do_reset();
      i_udp_pending = 1'b1;
      d = 0;
      for (int k = 0; k < MAXR; k++) begin
         wait_start(200, t);
         checks++;
         if (t < 0 || o_tx_sel !== 2'd2 || o_arp_oper !== 1'b0) begin
            errors++;
            $display("FAIL rq_start k=%0d got t=%0d sel=%0d oper=%b exp sel=2 oper=0", k, t, o_tx_sel, o_arp_oper);
         end
         if (k > 0) begin
            checks++;
            if (t - d < RETRY || t - d > RETRY + 3) begin
               errors++;
               $display("FAIL rq_spacing k=%0d got=%0d exp %0d..%0d", k, t - d, RETRY, RETRY + 3);
            end
         end
         finish_frame(10, d);
         checks++;
         if (o_arp_fail !== (k == MAXR - 1)) begin
            errors++;
            $display("FAIL arp_fail_pulse k=%0d got=%b exp=%b", k, o_arp_fail, k == MAXR - 1);
         end
      end
      nf = 0; ns = 0;
      repeat (300) begin tick(); nf += int'(o_arp_fail); ns += int'(o_tx_start); end
      checks++;
      if (nf != 0 || ns != 0) begin errors++; $display("FAIL backoff_hold got fails=%0d starts=%0d exp 0 0", nf, ns); end
      i_udp_pending = 1'b0;
      tick(); tick();
      i_udp_pending = 1'b1;
      wait_start(5, t);
      checks++;
      if (t < 0 || o_tx_sel !== 2'd2) begin errors++; $display("FAIL backoff_release got t=%0d sel=%0d exp sel=2", t, o_tx_sel); end
   endtask
   task automatic test_priority();
      int d, t, ng;
      do_reset();
      i_udp_pending = 1'b1; i_mac_valid = 1'b1; i_arp_resp_req = 1'b1;
      tick();
      checks++;
      if ({o_tx_start, o_tx_sel, o_arp_resp_ack} !== 4'b1_01_1) begin
         errors++;
         $display("FAIL prio_reply got=%b exp=1011", {o_tx_start, o_tx_sel, o_arp_resp_ack});
      end
      i_arp_resp_req = 1'b0;
      finish_frame(20, d);
      wait_start(40, t);
      checks++;
      if (t < 0 || t - d != IFG + 2 || o_tx_sel !== 2'd3 || o_udp_gate !== 1'b0) begin
         errors++;
         $display("FAIL prio_udp got gap=%0d sel=%0d gate=%b exp gap=%0d sel=3 gate=0", t - d, o_tx_sel, o_udp_gate, IFG + 2);
      end
      ng = 0;
      repeat (29) begin tick(); ng += int'(o_udp_gate); end
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      checks++;
      if (ng != 29) begin errors++; $display("FAIL gate_window got=%0d exp=29", ng); end
      checks++;
      if (o_udp_gate !== 1'b0) begin errors++; $display("FAIL gate_drop got=%b exp=0", o_udp_gate); end
   endtask
   task automatic test_mac_loss();
      int d, t;
      do_reset();
      i_udp_pending = 1'b1; i_mac_valid = 1'b1;
      wait_start(5, t);
      checks++;
      if (t < 0 || o_tx_sel !== 2'd3) begin errors++; $display("FAIL mac_udp_start got t=%0d sel=%0d exp sel=3", t, o_tx_sel); end
      repeat (10) tick();
      i_mac_valid = 1'b0;
      tick();
      checks++;
      if (o_udp_gate !== 1'b1) begin errors++; $display("FAIL gate_after_mac_drop got=%b exp=1", o_udp_gate); end
      finish_frame(10, d);
      wait_start(40, t);
      checks++;
      if (t < 0 || t - d != IFG + 2 || o_tx_sel !== 2'd2) begin
         errors++;
         $display("FAIL mac_loss_rq got gap=%0d sel=%0d exp gap=%0d sel=2", t - d, o_tx_sel, IFG + 2);
      end
   endtask
   task automatic test_reset_busy();
      int ns;
      logic [7:0] v;
      do_reset();
      i_arp_resp_req = 1'b1;
      tick();
      i_arp_resp_req = 1'b0;
      repeat (5) tick();
      i_aresetn = 1'b0;
      tick();
      v = {o_tx_start, o_arp_resp_ack, o_tx_sel, o_arp_oper, o_udp_gate, o_arp_fail, o_tx_timeout};
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL reset_busy got=%b exp=00000000", v); end
      i_aresetn = 1'b1; i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      ns = 0;
      repeat (20) begin
         tick();
         ns += int'({o_tx_start, o_arp_resp_ack, o_tx_sel, o_arp_oper, o_udp_gate, o_arp_fail} != 7'd0);
      end
      checks++;
      if (ns != 0) begin errors++; $display("FAIL late_done got active=%0d exp=0", ns); end
      i_arp_resp_req = 1'b1;
      tick();
      i_arp_resp_req = 1'b0;
      checks++;
      if (o_tx_start !== 1'b1 || o_tx_sel !== 2'd1) begin
         errors++;
         $display("FAIL idle_after_reset got start=%b sel=%0d exp 1 1", o_tx_start, o_tx_sel);
      end
   endtask
`ifdef TX_WATCHDOG_EN
   task automatic test_watchdog();
      int s, tw, t;
      do_reset();
      i_udp_pending = 1'b1; i_mac_valid = 1'b1;
      wait_start(5, s);
      tw = -1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (o_tx_timeout === 1'b1) begin tw = cyc; break; end
      end
      checks++;
      if (tw < 0 || tw - s != 51 || o_udp_gate !== 1'b0) begin
         errors++;
         $display("FAIL wd_timeout got offset=%0d gate=%b exp offset=51 gate=0", tw - s, o_udp_gate);
      end
      wait_start(40, t);
      checks++;
      if (t < 0 || t - tw != IFG + 1) begin errors++; $display("FAIL wd_ifg got=%0d exp=%0d", t - tw, IFG + 1); end
   endtask
`endif
   // Model: frames are transactions with a decision edge, a done edge, a gap
   // until the next decision, and ARP retries gated by time/backoff bookkeeping.
   task automatic test_random();
      int t, free_at, ok_at, cnt, st, clr_at, due, sel, nsel;
      bit busy, bo, start, fail;
      logic p_req, p_mac, p_udp, p_done;
      logic [7:0] exp_v, got_v;
      do_reset();
      free_at = 0; ok_at = 0; cnt = 0; st = 0; clr_at = -1; due = -1; sel = 0;
      busy = 1'b0; bo = 1'b0;
      for (int n = 0; n < 6000 && errors < 20; n++) begin
         p_req = i_arp_resp_req; p_mac = i_mac_valid; p_udp = i_udp_pending; p_done = i_tx_done;
         tick();
         t = cyc;
         start = 1'b0; fail = 1'b0;
         if (!busy && t >= free_at) begin
            nsel = p_req ? 1 : (p_udp && !p_mac && t >= ok_at && !bo) ? 2 : (p_udp && p_mac) ? 3 : 0;
            if (nsel != 0) begin start = 1'b1; busy = 1'b1; sel = nsel; st = t; end
         end else if (busy && t >= st + 2 && p_done) begin
            busy = 1'b0; free_at = t + IFG + 1; clr_at = t + IFG;
            if (sel == 2 && !p_mac) begin
               ok_at = t + RETRY + 1;
               cnt++;
               if (cnt == MAXR) begin cnt = 0; fail = 1'b1; end
            end
         end
         if (p_mac) begin cnt = 0; if (ok_at > t + 1) ok_at = t + 1; end
         bo = fail ? 1'b1 : (bo && p_udp && !p_mac);
         if (!busy && t == clr_at) sel = 0;
         exp_v = {start, start && sel == 1, 2'(sel), sel == 1, busy && sel == 3 && t >= st + 1, fail, 1'b0};
         got_v = {o_tx_start, o_arp_resp_ack, o_tx_sel, o_arp_oper, o_udp_gate, o_arp_fail, o_tx_timeout};
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", t, got_v, exp_v); end
         if (start) due = t + int'($urandom_range(1, 40));
         i_tx_done = (busy && t == due) || (!busy && $urandom_range(0, 30) == 0);
         if (start && sel == 1) i_arp_resp_req = 1'b0;
         else if (!i_arp_resp_req && $urandom_range(0, 150) == 0) i_arp_resp_req = 1'b1;
         if ($urandom_range(0, 400) == 0) i_mac_valid = !i_mac_valid;
         if ($urandom_range(0, 60) == 0) i_udp_pending = !i_udp_pending;
      end
   endtask
   initial begin
      test_reset();
      test_arp_reply();
      test_arp_retry();
      test_priority();
      test_mac_loss();
      test_reset_busy();
`ifdef TX_WATCHDOG_EN
      test_watchdog();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
